// File: rtl/booth_mult_arbiter.sv
// Round-robin arbiter/sequencer sharing one 8x8 Booth multiplier among NUM_REQ
// requesters: accept one operand pair, pulse enable, wait for the result, return it.
module booth_mult_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 63
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    input  logic [8*NUM_REQ-1:0] req_a_i,
    input  logic [8*NUM_REQ-1:0] req_b_i,
    output logic [NUM_REQ-1:0]   resp_valid_o,
    input  logic [NUM_REQ-1:0]   resp_ready_i,
    output logic [15:0]          resp_product_o,
    output logic                 resp_err_o,
    output logic                 busy_o,
    output logic                 mul_enable_o,
    output logic [7:0]           mul_multiplicand_o,
    output logic [7:0]           mul_multiplier_o,
    input  logic                 mul_data_valid_i,
    input  logic [15:0]          mul_product_i
);

    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [ID_W-1:0]  r_ptr;
    logic [ID_W-1:0]  r_id;
    logic [ID_W-1:0]  w_grant_id;
    logic             w_grant_found;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_a;
    logic [7:0]       r_b;
    logic [15:0]      r_product;
    logic             r_err;
    logic             w_timeout;
    int               w_idx;

    // First valid requester at or after r_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_id    = '0;
        w_idx         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
            if (!w_grant_found && req_valid_i[ID_W'(w_idx)]) begin
                w_grant_found = 1'b1;
                w_grant_id    = ID_W'(w_idx);
            end
        end
    end

    // Terminal count is one below the limit so RESP lands TIMEOUT_CYCLES+1 after ISSUE.
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) r_state <= S_IDLE;
        else           r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        mul_enable_o = 1'b0;
        busy_o       = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy_o = 1'b0;
                if (w_grant_found) w_state_next = S_ISSUE;
            end
            S_ISSUE: begin
                mul_enable_o = 1'b1;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (mul_data_valid_i || w_timeout) w_state_next = S_RESP;
            end
            S_RESP: begin
                if (resp_ready_i[r_id]) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Ready is gated by reset because the grant path is combinational from req_valid_i.
    always_comb begin
        req_ready_o  = '0;
        resp_valid_o = '0;
        if (reset_ni && r_state == S_IDLE && w_grant_found) req_ready_o[w_grant_id] = 1'b1;
        if (r_state == S_RESP) resp_valid_o[r_id] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_ptr     <= '0;
            r_id      <= '0;
            r_cnt     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_product <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_found) begin
                        r_id <= w_grant_id;
                        r_a  <= req_a_i[{w_grant_id, 3'b000} +: 8];
                        r_b  <= req_b_i[{w_grant_id, 3'b000} +: 8];
                    end
                end
                S_ISSUE: r_cnt <= '0;
                S_WAIT: begin
                    if (mul_data_valid_i) begin
                        r_product <= mul_product_i;
                        r_err     <= 1'b0;
                    end else if (w_timeout) begin
                        r_product <= '0;
                        r_err     <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (resp_ready_i[r_id])
                        r_ptr <= (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + ID_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign mul_multiplicand_o = r_a;
    assign mul_multiplier_o   = r_b;
    assign resp_product_o     = r_product;
    assign resp_err_o         = r_err;

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Scoreboard bench for booth_mult_arbiter with a behavioural 17-cycle multiplier model.
module tb_booth_mult_arbiter;
    localparam int NREQ = 4;
    localparam int TMO  = 63;

    logic                clk = 1'b0;
    logic                reset_ni = 1'b0;
    logic [NREQ-1:0]     req_valid_i = '0;
    logic [NREQ-1:0]     req_ready_o;
    logic [8*NREQ-1:0]   req_a_i = '0;
    logic [8*NREQ-1:0]   req_b_i = '0;
    logic [NREQ-1:0]     resp_valid_o;
    logic [NREQ-1:0]     resp_ready_i = '0;
    logic [15:0]         resp_product_o;
    logic                resp_err_o;
    logic                busy_o;
    logic                mul_enable_o;
    logic [7:0]          mul_multiplicand_o;
    logic [7:0]          mul_multiplier_o;
    logic                mul_data_valid_i = 1'b0;
    logic [15:0]         mul_product_i = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct packed {
        logic [2:0]  id;
        logic [15:0] prod;
        logic        err;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    booth_mult_arbiter #(.NUM_REQ(NREQ), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk), .reset_ni(reset_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_a_i(req_a_i), .req_b_i(req_b_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_product_o(resp_product_o), .resp_err_o(resp_err_o),
        .busy_o(busy_o), .mul_enable_o(mul_enable_o),
        .mul_multiplicand_o(mul_multiplicand_o), .mul_multiplier_o(mul_multiplier_o),
        .mul_data_valid_i(mul_data_valid_i), .mul_product_i(mul_product_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier model: data_valid asserted in the 17th cycle after the enable cycle.
    logic signed [15:0] ma, mb;
    int mcnt = 0;
    bit mul_dead = 1'b0;
    int stray_req = 0;
    int stray_seen = 0;
    always @(negedge clk) begin
        if (!reset_ni) begin
            mcnt = 0;
            mul_data_valid_i = 1'b0;
        end else begin
            mul_data_valid_i = 1'b0;
            if (stray_req != stray_seen) begin
                stray_seen = stray_req;
                mul_data_valid_i = 1'b1;
                mul_product_i = 16'h1234;
            end
            if (mcnt > 0) begin
                mcnt = mcnt - 1;
                if (mcnt == 0 && !mul_dead) begin
                    mul_data_valid_i = 1'b1;
                    mul_product_i = ma * mb;
                end
            end
            if (mul_enable_o) begin
                mcnt = 17;
                ma = 16'($signed(mul_multiplicand_o));
                mb = 16'($signed(mul_multiplier_o));
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bounded wait expired (cycle %0d)", name, cyc);
    endtask

    function automatic int oh2id(input logic [NREQ-1:0] v);
        int r = -1;
        for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Response monitor: pops the scoreboard on every response handshake.
    always @(negedge clk) begin
        if (reset_ni) begin
            if (req_ready_o != '0) chk("req_ready_onehot", $countones(req_ready_o), 1);
            if ((resp_valid_o & resp_ready_i) != '0) begin
                chk("resp_valid_onehot", $countones(resp_valid_o), 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: valid=%b product=%h, expected no response (cycle %0d)",
                             resp_valid_o, resp_product_o, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("resp_id", oh2id(resp_valid_o), 32'(mon_e.id));
                    chk("resp_product", resp_product_o, 32'(mon_e.prod));
                    chk("resp_err", resp_err_o, 32'(mon_e.err));
                end
            end
        end
    end

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a_i[8*i +: 8] = a;
        req_b_i[8*i +: 8] = b;
        req_valid_i[i] = 1'b1;
    endtask

    task automatic push_exp(input int id, input logic [15:0] p, input logic e);
        exp_t x;
        x.id = 3'(id);
        x.prod = p;
        x.err = e;
        exp_q.push_back(x);
    endtask

    task automatic wait_accept(input int maxc, output int id, output int t);
        id = -1;
        t = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if ((req_valid_i & req_ready_o) != '0) begin
                id = oh2id(req_ready_o);
                t = cyc;
                break;
            end
        end
        if (t < 0) fail_now("accept_wait");
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp_rise(input int maxc, output int t);
        t = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (resp_valid_o != '0) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) fail_now("resp_wait");
    endtask

    task automatic wait_drain(input int maxc);
        for (int i = 0; i < maxc; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0) fail_now("drain_wait");
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready_o, 0);
        chk({tag, "_resp_valid"}, resp_valid_o, 0);
        chk({tag, "_product"}, resp_product_o, 0);
        chk({tag, "_err"}, resp_err_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_enable"}, mul_enable_o, 0);
        chk({tag, "_mcand"}, mul_multiplicand_o, 0);
        chk({tag, "_mplier"}, mul_multiplier_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    int rr_ord[5] = '{0, 1, 2, 3, 0};
    logic [15:0] rr_p[4] = '{16'h000C, 16'h0064, 16'hFFCE, 16'h3F01};

    initial begin
        int id, t, t2, r, seen;
        // Reset state
        reset_ni = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("rst");
        reset_ni = 1'b1;
        resp_ready_i = '1;
        @(posedge clk);
        #1;

        // Single request with latency checks
        push_exp(0, 16'd63, 1'b0);
        set_req(0, 8'd7, 8'd9);
        wait_accept(10, id, t);
        req_valid_i = '0;
        chk("single_id", id, 0);
        @(negedge clk);
        chk("enable_T1", mul_enable_o, 1);
        chk("busy_T1", busy_o, 1);
        chk("mcand_T1", mul_multiplicand_o, 8'd7);
        chk("mplier_T1", mul_multiplier_o, 8'd9);
        @(negedge clk);
        chk("enable_T2", mul_enable_o, 0);
        wait_resp_rise(40, r);
        chk("single_latency", r - t, 19);
        wait_drain(10);

        // Signed operands
        push_exp(2, 16'hFFF1, 1'b0);
        set_req(2, 8'hFD, 8'd5);
        wait_accept(10, id, t);
        req_valid_i = '0;
        chk("signed1_id", id, 2);
        wait_drain(40);
        push_exp(2, 16'h4000, 1'b0);
        set_req(2, 8'h80, 8'h80);
        wait_accept(10, id, t);
        req_valid_i = '0;
        wait_drain(40);
        push_exp(3, 16'hFF81, 1'b0);
        set_req(3, 8'h7F, 8'hFF);
        wait_accept(10, id, t);
        req_valid_i = '0;
        chk("signed3_id", id, 3);
        wait_drain(40);

        // Round-robin with all requesters held valid
        for (int i = 0; i < 5; i++) push_exp(rr_ord[i], rr_p[rr_ord[i]], 1'b0);
        set_req(0, 8'd3, 8'd4);
        set_req(1, 8'hF6, 8'hF6);
        set_req(2, 8'd25, 8'hFE);
        set_req(3, 8'h7F, 8'h7F);
        for (int i = 0; i < 5; i++) begin
            wait_accept(60, id, t);
            chk("rr_order", id, rr_ord[i]);
        end
        req_valid_i = '0;
        wait_drain(40);

        // Response backpressure on requester 1
        resp_ready_i = 4'b1101;
        push_exp(1, 16'hFFD6, 1'b0);
        push_exp(2, 16'h0006, 1'b0);
        set_req(1, 8'd6, 8'hF9);
        set_req(2, 8'd2, 8'd3);
        wait_accept(10, id, t);
        req_valid_i[1] = 1'b0;
        chk("bp_id", id, 1);
        wait_resp_rise(40, r);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp_valid_held", resp_valid_o, 4'b0010);
            chk("bp_product_held", resp_product_o, 16'hFFD6);
            chk("bp_no_accept", req_ready_o, 0);
        end
        @(posedge clk);
        #1;
        resp_ready_i = '1;
        wait_accept(10, id, t2);
        req_valid_i = '0;
        chk("bp_next_id", id, 2);
        chk("bp_next_accept", t2 - r, 11);
        wait_drain(40);

        // Timeout with a silent multiplier, then a stray result in IDLE
        mul_dead = 1'b1;
        push_exp(3, 16'h0000, 1'b1);
        set_req(3, 8'd5, 8'd5);
        wait_accept(10, id, t);
        req_valid_i = '0;
        chk("tmo_id", id, 3);
        wait_resp_rise(100, r);
        chk("tmo_latency", r - (t + 1), TMO + 1);
        chk("tmo_err", resp_err_o, 1);
        chk("tmo_product", resp_product_o, 0);
        wait_drain(10);
        mul_dead = 1'b0;
        stray_req++;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (resp_valid_o != '0 || busy_o) seen++;
        end
        chk("stray_ignored", seen, 0);
        @(posedge clk);
        #1;

        // Reset during WAIT, then a fresh request
        set_req(0, 8'd9, 8'd9);
        wait_accept(10, id, t);
        req_valid_i = '0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_busy", busy_o, 1);
        reset_ni = 1'b0;
        set_req(1, 8'h81, 8'd2);
        @(negedge clk);
        chk_reset_outputs("midrst");
        push_exp(1, 16'hFF02, 1'b0);
        @(posedge clk);
        #1;
        reset_ni = 1'b1;
        wait_accept(10, id, t);
        req_valid_i = '0;
        chk("post_rst_id", id, 1);
        wait_drain(40);

        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
